exc_commit_unit: RTL and testbench

- Parametrised successor to the ID-stage exception flag generator.
- Carries per-instruction exception vectors, PC, delay-slot and bad-address information through a configurable number of pipeline slots to the commit point.
- At commit, samples synchronised hardware and software interrupts, resolves the highest-priority cause and emits one registered exception or ERET event to CP0 and the fetch redirect logic.
- Holds a flush until fetch acknowledges the redirect.

---
 rtl/exc_commit_unit.sv | 195 +++++++++++++++++++
 tb/tb_exc_commit_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit_unit.sv
// Exception commit unit: carries ID exception info through PIPE_DEPTH slots and resolves one event per commit.
// Optional EXC_PERF_CNT_EN macro builds a saturating committed-exception counter on exc_count.
module exc_commit_unit #(
  parameter int EXC_W       = 8,
  parameter int ADDR_W      = 32,
  parameter int PIPE_DEPTH  = 2,
  parameter int INT_W       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [EXC_W-1:0]  in_exc_type,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_badvaddr,
  input  logic              in_is_store,
  input  logic              in_delayslot,
  input  logic              stall,
  input  logic [INT_W-1:0]  int_i,
  input  logic [1:0]        sw_ip,
  input  logic [INT_W+1:0]  status_im,
  input  logic              status_ie,
  input  logic              status_exl,
  input  logic              redirect_ack,
  output logic              exc_valid,
  output logic [4:0]        exc_code,
  output logic [ADDR_W-1:0] exc_epc,
  output logic              exc_bd,
  output logic [ADDR_W-1:0] exc_badvaddr,
  output logic              exc_bva_we,
  output logic              eret_valid,
  output logic              flush,
  output logic [15:0]       exc_count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // Vector bit positions: {eret, ade, syscall, break, tp, overflow, ri, if}
  localparam int B_IF = 0, B_RI = 1, B_OV = 2, B_TP = 3;
  localparam int B_BRK = 4, B_SYS = 5, B_ADE = 6, B_ERET = 7;

  logic [0:0] state_reg;

  logic [SYNC_STAGES-1:0][INT_W-1:0]  sync_reg;
  logic [PIPE_DEPTH-1:0]              slot_valid_reg;
  logic [PIPE_DEPTH-1:0][EXC_W-1:0]   slot_exc_reg;
  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]  slot_pc_reg;
  logic [PIPE_DEPTH-1:0][ADDR_W-1:0]  slot_bva_reg;
  logic [PIPE_DEPTH-1:0]              slot_store_reg;
  logic [PIPE_DEPTH-1:0]              slot_ds_reg;

  logic              exc_valid_reg, eret_valid_reg, exc_bd_reg, exc_bva_we_reg;
  logic [4:0]        exc_code_reg;
  logic [ADDR_W-1:0] exc_epc_reg, exc_bva_reg;

  logic              running, commit, int_pend;
  logic              exc_hit, bva_we_next, take_exc, take_eret, take_any;
  logic [4:0]        code_next;
  logic [ADDR_W-1:0] bva_next, epc_next;
  logic [EXC_W-1:0]  head_exc;
  logic [ADDR_W-1:0] head_pc;

  assign running  = (state_reg == ST_RUN);
  assign head_exc = slot_exc_reg[PIPE_DEPTH-1];
  assign head_pc  = slot_pc_reg[PIPE_DEPTH-1];
  assign commit   = slot_valid_reg[PIPE_DEPTH-1] & ~stall & running;
  assign int_pend = (|({sync_reg[SYNC_STAGES-1], sw_ip} & status_im)) & status_ie & ~status_exl;
  assign epc_next = slot_ds_reg[PIPE_DEPTH-1] ? (head_pc - ADDR_W'(4)) : head_pc;

  always_comb begin
    exc_hit     = 1'b1;
    code_next   = 5'd0;
    bva_we_next = 1'b0;
    bva_next    = head_pc;
    if (int_pend) begin
      code_next = 5'd0;
    end else if (head_exc[B_IF]) begin
      code_next   = 5'd4;
      bva_we_next = 1'b1;
    end else if (head_exc[B_RI]) begin
      code_next = 5'd10;
    end else if (head_exc[B_OV]) begin
      code_next = 5'd12;
    end else if (head_exc[B_TP]) begin
      code_next = 5'd13;
    end else if (head_exc[B_SYS]) begin
      code_next = 5'd8;
    end else if (head_exc[B_BRK]) begin
      code_next = 5'd9;
    end else if (head_exc[B_ADE]) begin
      code_next   = slot_store_reg[PIPE_DEPTH-1] ? 5'd5 : 5'd4;
      bva_we_next = 1'b1;
      bva_next    = slot_bva_reg[PIPE_DEPTH-1];
    end else begin
      exc_hit = 1'b0;
    end
  end

  // ERET only wins when nothing of higher priority is pending on the same instruction
  assign take_exc  = commit & exc_hit;
  assign take_eret = commit & ~exc_hit & head_exc[B_ERET];
  assign take_any  = take_exc | take_eret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], int_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_reg <= '0;
      slot_exc_reg   <= '0;
      slot_pc_reg    <= '0;
      slot_bva_reg   <= '0;
      slot_store_reg <= '0;
      slot_ds_reg    <= '0;
    end else begin
      if (!running || take_any) begin
        slot_valid_reg <= '0;
      end else if (!stall) begin
        slot_valid_reg[0] <= in_valid;
        for (int k = 1; k < PIPE_DEPTH; k++) slot_valid_reg[k] <= slot_valid_reg[k-1];
      end
      if (!stall) begin
        slot_exc_reg[0]   <= in_exc_type;
        slot_pc_reg[0]    <= in_pc;
        slot_bva_reg[0]   <= in_badvaddr;
        slot_store_reg[0] <= in_is_store;
        slot_ds_reg[0]    <= in_delayslot;
        for (int k = 1; k < PIPE_DEPTH; k++) begin
          slot_exc_reg[k]   <= slot_exc_reg[k-1];
          slot_pc_reg[k]    <= slot_pc_reg[k-1];
          slot_bva_reg[k]   <= slot_bva_reg[k-1];
          slot_store_reg[k] <= slot_store_reg[k-1];
          slot_ds_reg[k]    <= slot_ds_reg[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      exc_valid_reg  <= 1'b0;
      eret_valid_reg <= 1'b0;
      exc_code_reg   <= '0;
      exc_epc_reg    <= '0;
      exc_bd_reg     <= 1'b0;
      exc_bva_we_reg <= 1'b0;
      exc_bva_reg    <= '0;
    end else begin
      exc_valid_reg  <= take_exc;
      eret_valid_reg <= take_eret;
      exc_bva_we_reg <= take_exc & bva_we_next;
      if (take_exc) begin
        exc_code_reg <= code_next;
        exc_epc_reg  <= epc_next;
        exc_bd_reg   <= slot_ds_reg[PIPE_DEPTH-1];
      end
      if (take_exc && bva_we_next) exc_bva_reg <= bva_next;
      case (state_reg)
        ST_RUN:   if (take_any) state_reg <= ST_FLUSH;
        default:  if (redirect_ack) state_reg <= ST_RUN;
      endcase
    end
  end

`ifdef EXC_PERF_CNT_EN
  logic [15:0] count_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (take_exc && count_reg != 16'hFFFF) begin
      count_reg <= count_reg + 16'd1;
    end
  end
  assign exc_count = count_reg;
`else
  assign exc_count = '0;
`endif

  assign exc_valid    = exc_valid_reg;
  assign eret_valid   = eret_valid_reg;
  assign exc_code     = exc_code_reg;
  assign exc_epc      = exc_epc_reg;
  assign exc_bd       = exc_bd_reg;
  assign exc_bva_we   = exc_bva_we_reg;
  assign exc_badvaddr = exc_bva_reg;
  assign flush        = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_exc_commit_unit.sv
// Scoreboard bench for exc_commit_unit: expected events queued at drive time, popped when the DUT reports one.
module tb_exc_commit_unit;
`ifdef EXC_PERF_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_is_store, in_delayslot, stall;
  logic [7:0]  in_exc_type;
  logic [31:0] in_pc, in_badvaddr;
  logic [5:0]  int_i;
  logic [1:0]  sw_ip;
  logic [7:0]  status_im;
  logic        status_ie, status_exl, redirect_ack;
  logic        exc_valid, exc_bd, exc_bva_we, eret_valid, flush;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_badvaddr;
  logic [15:0] exc_count;

  typedef struct {
    logic        is_eret;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        bva_we;
    logic [31:0] bva;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   mon_cnt = 0;
  int   fcnt;

  always #5 clk = ~clk;

  exc_commit_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_exc_type(in_exc_type),
    .in_pc(in_pc), .in_badvaddr(in_badvaddr), .in_is_store(in_is_store),
    .in_delayslot(in_delayslot), .stall(stall), .int_i(int_i), .sw_ip(sw_ip),
    .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
    .redirect_ack(redirect_ack), .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_epc(exc_epc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
    .exc_bva_we(exc_bva_we), .eret_valid(eret_valid), .flush(flush),
    .exc_count(exc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_exc(input logic [4:0] code, input logic [31:0] epc, input logic bd,
                          input logic bva_we, input logic [31:0] bva);
    exp_t e;
    e.is_eret = 1'b0; e.code = code; e.epc = epc; e.bd = bd; e.bva_we = bva_we; e.bva = bva;
    exp_q.push_back(e);
  endtask

  task automatic push_eret(input logic [31:0] bva_hold);
    exp_t e;
    e.is_eret = 1'b1; e.code = 5'd0; e.epc = 32'd0; e.bd = 1'b0; e.bva_we = 1'b0; e.bva = bva_hold;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [31:0] pc, input logic [7:0] vec, input logic ds,
                      input logic st, input logic [31:0] bva);
    @(posedge clk); #1;
    in_valid = 1'b1; in_exc_type = vec; in_pc = pc; in_delayslot = ds;
    in_is_store = st; in_badvaddr = bva;
    $display("send pc=0x%0h vec=0x%02h ds=%0d st=%0d bva=0x%0h", pc, vec, ds, st, bva);
    @(posedge clk); #1;
    in_valid = 1'b0; in_exc_type = 8'h00; in_delayslot = 1'b0; in_is_store = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
    for (int i = 0; i < 20 && flush; i++) @(negedge clk);
    check({tag, "_flush_end"}, flush, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (exc_valid || eret_valid)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {exc_valid, eret_valid}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        if (!mon_e.is_eret) mon_cnt++;
        $display("event exc=%0d eret=%0d code=%0d epc=0x%0h bd=%0d bva_we=%0d bva=0x%0h cnt=%0d",
                 exc_valid, eret_valid, exc_code, exc_epc, exc_bd, exc_bva_we, exc_badvaddr, exc_count);
        check("exc_valid", exc_valid, !mon_e.is_eret);
        check("eret_valid", eret_valid, mon_e.is_eret);
        if (!mon_e.is_eret) begin
          check("exc_code", exc_code, mon_e.code);
          check("exc_epc", exc_epc, mon_e.epc);
          check("exc_bd", exc_bd, mon_e.bd);
        end
        check("exc_bva_we", exc_bva_we, mon_e.bva_we);
        check("exc_badvaddr", exc_badvaddr, mon_e.bva);
        check("flush_on_event", flush, 1'b1);
        check("exc_count", exc_count, CNT_EN ? 16'(mon_cnt) : 16'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_exc_type = 8'h00; in_pc = 32'd0; in_badvaddr = 32'd0;
    in_is_store = 1'b0; in_delayslot = 1'b0; stall = 1'b0; int_i = 6'd0; sw_ip = 2'd0;
    status_im = 8'h00; status_ie = 1'b0; status_exl = 1'b0; redirect_ack = 1'b1;
    #12;
    check("rst_exc_valid", exc_valid, 1'b0);
    check("rst_eret_valid", eret_valid, 1'b0);
    check("rst_flush", flush, 1'b0);
    check("rst_code", exc_code, 5'd0);
    check("rst_epc", exc_epc, 32'd0);
    check("rst_count", exc_count, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reserved instruction
    push_exc(5'd10, 32'h100, 1'b0, 1'b0, 32'h0);
    send(32'h100, 8'h02, 1'b0, 1'b0, 32'h0);
    drain("ri");

    // Overflow beats syscall; delay-slot EPC
    push_exc(5'd12, 32'h200, 1'b1, 1'b0, 32'h0);
    send(32'h204, 8'h24, 1'b1, 1'b0, 32'h0);
    drain("ovsys");

    // Hardware interrupt on clean instruction
    int_i = 6'b000100; status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
    repeat (3) @(posedge clk);
    push_exc(5'd0, 32'h300, 1'b0, 1'b0, 32'h0);
    send(32'h300, 8'h00, 1'b0, 1'b0, 32'h0);
    drain("int");

    // EXL masks interrupts: clean instruction commits silently
    status_exl = 1'b1;
    send(32'h304, 8'h00, 1'b0, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    check("exl_no_flush", flush, 1'b0);
    int_i = 6'd0; status_ie = 1'b0; status_exl = 1'b0; status_im = 8'h00;
    repeat (3) @(posedge clk);

    // AdES then ERET (BadVAddr holds across ERET)
    push_exc(5'd5, 32'h400, 1'b0, 1'b1, 32'h1003);
    send(32'h400, 8'h40, 1'b0, 1'b1, 32'h1003);
    drain("ades");
    push_eret(32'h1003);
    send(32'h404, 8'h80, 1'b0, 1'b0, 32'h0);
    drain("eret");

    // Fetch fault outranks ade and eret; badvaddr is the PC
    push_exc(5'd4, 32'h500, 1'b0, 1'b1, 32'h500);
    send(32'h500, 8'hC1, 1'b0, 1'b0, 32'h2222);
    drain("if");

    // Break in delay slot at pc=0 wraps the EPC
    push_exc(5'd9, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h500);
    send(32'h0, 8'h10, 1'b1, 1'b0, 32'h0);
    drain("brk_wrap");

    // Trap with redirect_ack low for 4 cycles; inputs during flush are ignored
    redirect_ack = 1'b0;
    push_exc(5'd13, 32'h600, 1'b0, 1'b0, 32'h500);
    send(32'h600, 8'h08, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !flush; i++) @(negedge clk);
    fcnt = flush ? 1 : 0;
    in_valid = 1'b1; in_exc_type = 8'h02; in_pc = 32'h700;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (flush) fcnt++;
    end
    redirect_ack = 1'b1; in_valid = 1'b0; in_exc_type = 8'h00;
    @(negedge clk);
    check("flush_dropped", flush, 1'b0);
    check("flush_cycles", fcnt, 5);
    repeat (6) @(negedge clk);
    check("flush_ignored_inputs", exp_q.size(), 0);

    // Stall at commit holds the event
    push_exc(5'd12, 32'h800, 1'b0, 1'b0, 32'h500);
    @(posedge clk); #1;
    in_valid = 1'b1; in_exc_type = 8'h04; in_pc = 32'h800;
    @(posedge clk); #1;
    in_valid = 1'b0; in_exc_type = 8'h00;
    @(posedge clk); #1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_no_exc", exc_valid, 1'b0);
      check("stall_no_flush", flush, 1'b0);
    end
    stall = 1'b0;
    drain("stall");

    check("count_total", exc_count, CNT_EN ? 16'd8 : 16'd0);

    // Reset while flushing
    redirect_ack = 1'b0;
    push_exc(5'd10, 32'h900, 1'b0, 1'b0, 32'h500);
    send(32'h900, 8'h02, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !flush; i++) @(negedge clk);
    check("pre_rst_flush", flush, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_flush", flush, 1'b0);
    check("async_rst_count", exc_count, 16'd0);
    check("async_rst_exc_valid", exc_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; redirect_ack = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_flush", flush, 1'b0);
    check("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
